// File: rtl/rename_dispatch_buffer.sv
// Purpose: in-order FIFO of renamed bundles between rename and dispatch.
// Latency: at least 1 cycle from push to head, with no bypass path.
// Backpressure: in_ready drops when full unless a pop frees a slot that cycle; recover flushes everything.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module rename_dispatch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 recover,
  input  logic                                                 in_valid,
  input  logic [`RENAME_WIDTH-1:0]                             in_slot_valid,
  input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    in_prs1,
  input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    in_prs2,
  input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    in_prd,
  input  logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    in_prev_rd,
  input  logic [`RENAME_WIDTH-1:0]                             in_prev_rd_valid,
  output logic                                                 in_ready,
  output logic                                                 stall,
  output logic                                                 out_valid,
  output logic [`RENAME_WIDTH-1:0]                             out_slot_valid,
  output logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    out_prs1,
  output logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    out_prs2,
  output logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    out_prd,
  output logic [`RENAME_WIDTH-1:0][`PRF_INT_INDEX_SIZE-1:0]    out_prev_rd,
  output logic [`RENAME_WIDTH-1:0]                             out_prev_rd_valid,
  input  logic                                                 out_ready,
  output logic [$clog2(DEPTH):0]                               count
);

  localparam int W  = `RENAME_WIDTH;
  localparam int P  = `PRF_INT_INDEX_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [W-1:0]        slot_valid;
    logic [W-1:0][P-1:0] prs1;
    logic [W-1:0][P-1:0] prs2;
    logic [W-1:0][P-1:0] prd;
    logic [W-1:0][P-1:0] prev_rd;
    logic [W-1:0]        prev_rd_valid;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_ent;
  entry_t          head_ent;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;

  assign in_ent = {in_slot_valid, in_prs1, in_prs2, in_prd, in_prev_rd, in_prev_rd_valid};

  // While reset is held the pointers are being cleared, so advertise the empty-buffer handshake.
  assign out_valid = reset & ~recover & (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = ~reset | (~recover & ((count_q < FULL) | pop));
  assign stall     = ~in_ready;
  assign push      = in_valid & in_ready & reset & ~recover;
  assign count     = count_q;

  always_ff @(posedge clock) begin
    if (!reset || recover) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= in_ent;
  end

  assign head_ent          = out_valid ? mem[head] : '0;
  assign out_slot_valid    = head_ent.slot_valid;
  assign out_prs1          = head_ent.prs1;
  assign out_prs2          = head_ent.prs2;
  assign out_prd           = head_ent.prd;
  assign out_prev_rd       = head_ent.prev_rd;
  assign out_prev_rd_valid = head_ent.prev_rd_valid;

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset || recover)
    push |-> ((count_q < FULL) || pop));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset || recover)
    pop |-> (count_q != '0));

endmodule

// File: tb/tb_rename_dispatch_buffer.sv
// Bench for rename_dispatch_buffer: table-driven cycles checked against a reference queue.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 7
`endif

module tb_rename_dispatch_buffer;
  localparam int DEPTH = 4;
  localparam int W = `RENAME_WIDTH;
  localparam int P = `PRF_INT_INDEX_SIZE;

  typedef struct packed {
    logic [W-1:0]        slot_valid;
    logic [W-1:0][P-1:0] prs1;
    logic [W-1:0][P-1:0] prs2;
    logic [W-1:0][P-1:0] prd;
    logic [W-1:0][P-1:0] prev_rd;
    logic [W-1:0]        prev_rd_valid;
  } pay_t;

  typedef struct {
    bit iv;
    bit ordy;
    bit rec;
    bit zs;
    int prd;
    int cnt;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic recover = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pay_t in_p = '0;
  pay_t out_p;
  logic in_ready, stall, out_valid;
  logic [W-1:0]        out_slot_valid, out_prev_rd_valid;
  logic [W-1:0][P-1:0] out_prs1, out_prs2, out_prd, out_prev_rd;
  logic [$clog2(DEPTH):0] count;

  pay_t q[$];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  int max_count = 0;

  always #5 clock = ~clock;

  rename_dispatch_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .recover(recover), .in_valid(in_valid),
    .in_slot_valid(in_p.slot_valid), .in_prs1(in_p.prs1), .in_prs2(in_p.prs2),
    .in_prd(in_p.prd), .in_prev_rd(in_p.prev_rd), .in_prev_rd_valid(in_p.prev_rd_valid),
    .in_ready(in_ready), .stall(stall), .out_valid(out_valid),
    .out_slot_valid(out_slot_valid), .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_prd(out_prd), .out_prev_rd(out_prev_rd), .out_prev_rd_valid(out_prev_rd_valid),
    .out_ready(out_ready), .count(count)
  );

  assign out_p = {out_slot_valid, out_prs1, out_prs2, out_prd, out_prev_rd, out_prev_rd_valid};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic make_pay(input int prd0, input bit zs, output pay_t p);
    for (int s = 0; s < W; s++) begin
      p.prs1[s]    = P'($urandom);
      p.prs2[s]    = P'($urandom);
      p.prd[s]     = P'($urandom);
      p.prev_rd[s] = P'($urandom);
    end
    p.slot_valid    = zs ? '0 : W'($urandom_range(1, (1 << W) - 1));
    p.prev_rd_valid = W'($urandom);
    p.prd[0]        = P'(prd0);
  endtask

  // One clock: drive, check combinational outputs against the model, clock, update model, check count.
  task automatic step(input bit iv, input bit ordy, input bit rec, input bit zs,
                      input int prd0, input int exp_cnt);
    pay_t p;
    bit exp_ov, exp_ir;
    @(negedge clock);
    make_pay(prd0, zs, p);
    in_p = p; in_valid = iv; out_ready = ordy; recover = rec;
    #1;
    exp_ov = !rec && (q.size() != 0);
    exp_ir = !rec && ((q.size() < DEPTH) || (exp_ov && ordy));
    chk("in_ready", in_ready, exp_ir);
    chk("stall", stall, !exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("payload", out_p, exp_ov ? q[0] : pay_t'('0));
    @(posedge clock);
    #1;
    if (rec) q.delete();
    else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (iv && exp_ir) q.push_back(p);
    end
    if (int'(count) > max_count) max_count = int'(count);
    chk("count_model", count, q.size());
    if (exp_cnt >= 0) chk("count_table", count, exp_cnt);
  endtask

  task automatic pulse_reset(input bit iv_during);
    pay_t p;
    @(negedge clock);
    make_pay(99, 0, p);
    in_p = p; reset = 1'b0; in_valid = iv_during; out_ready = 1'b1; recover = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_payload", out_p, 0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_payload", out_p, 0);
  endtask

  initial begin
    // fill, dropped 5th push, drain order
    tbl.push_back('{1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 2, 2});
    tbl.push_back('{1, 0, 0, 0, 3, 3});
    tbl.push_back('{1, 0, 0, 0, 4, 4});
    tbl.push_back('{1, 0, 0, 0, 5, 4});
    tbl.push_back('{0, 1, 0, 0, 0, 3});
    tbl.push_back('{0, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0});
    // push and pop together while full
    tbl.push_back('{1, 0, 0, 0, 5, 1});
    tbl.push_back('{1, 0, 0, 0, 6, 2});
    tbl.push_back('{1, 0, 0, 0, 7, 3});
    tbl.push_back('{1, 0, 0, 0, 8, 4});
    tbl.push_back('{1, 1, 0, 0, 9, 4});
    tbl.push_back('{0, 1, 0, 0, 0, 3});
    tbl.push_back('{0, 1, 0, 0, 0, 2});
    tbl.push_back('{0, 1, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0});
    // recover with concurrent push and pop request
    tbl.push_back('{1, 0, 0, 0, 11, 1});
    tbl.push_back('{1, 0, 0, 0, 12, 2});
    tbl.push_back('{1, 0, 0, 0, 13, 3});
    tbl.push_back('{1, 1, 1, 0, 14, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0});
    // bundle with no valid slots is still carried through
    tbl.push_back('{1, 1, 0, 1, 15, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0});

    pulse_reset(1'b0);

    foreach (tbl[i]) step(tbl[i].iv, tbl[i].ordy, tbl[i].rec, tbl[i].zs, tbl[i].prd, tbl[i].cnt);

    // wrap-around with toggling out_ready
    for (int i = 0; i < 10; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b0, 20 + i, -1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, -1);
    chk("wrap_drained", count, 0);
    chk("count_max", max_count > DEPTH, 0);

    // reset mid-stream discards contents; a push during reset is ignored
    step(1'b1, 1'b0, 1'b0, 1'b0, 30, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 31, 2);
    pulse_reset(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7, 1);
    chk("post_reset_head", out_prd[0], 7);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rename_dispatch_buffer.md
RENAME_DISPATCH_BUFFER -- requirements
Module: rename_dispatch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning bundle-entry capacity; legal values are a power of two, 2..16.
REQ-002 SHALL use `RENAME_WIDTH (W) and `PRF_INT_INDEX_SIZE (P) from the common micro-op header.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low; asserted when 0.
REQ-005 recover  input  1  branch-mispredict flush.
REQ-006 in_valid  input  1  rename stage presents a bundle.
REQ-007 in_slot_valid  input  W  per-slot uop valid within the bundle.
REQ-008 in_prs1, in_prs2, in_prd, in_prev_rd  input  W x P each  renamed register tags.
REQ-009 in_prev_rd_valid  input  W  per-slot previous-mapping valid.
REQ-010 in_ready  output  1  buffer accepts a bundle this cycle.
REQ-011 stall  output  1  equals !in_ready; feeds the rename stall input.
REQ-012 out_valid  output  1  head bundle is available.
REQ-013 out_slot_valid, out_prs1, out_prs2, out_prd, out_prev_rd, out_prev_rd_valid  output  widths mirror the inputs  head bundle payload.
REQ-014 out_ready  input  1  dispatch consumes the head bundle.
REQ-015 count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL be a circular FIFO of DEPTH bundle entries with head and tail pointers of clog2(DEPTH) bits each, wrapping modulo DEPTH, plus a separate occupancy counter.
REQ-017 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL be (count < DEPTH) | pop; a full buffer accepts a push in the same cycle as a pop.
REQ-019 out_valid SHALL be (count != 0); there is no bypass, so a pushed bundle is visible at the outputs no earlier than the next cycle (1-cycle minimum latency).
REQ-020 out_* payload SHALL be driven combinationally from the head entry; when out_valid=0, all out_* payload outputs are 0.
REQ-021 On push, the entry at tail SHALL capture all in_* payload and tail advances by 1.
REQ-022 On pop, head SHALL advance by 1.
REQ-023 count SHALL update as count + push - pop; simultaneous push and pop leave count unchanged.
REQ-024 A bundle with in_valid=1 and in_slot_valid=0 SHALL still be stored and dispatched unchanged.
REQ-025 When recover=1 (reset deasserted), the next state SHALL be head=tail=count=0, and push and pop in that cycle SHALL be ignored.
REQ-026 While recover=1, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-027 Ordering SHALL be strict FIFO; there is no reordering or partial-bundle pop.
REQ-028 SHALL never overflow or underflow; assertions check push only when count<DEPTH or pop, and pop only when count>0.

Reset
REQ-029 With reset=0 at a posedge, head, tail and count SHALL clear to 0; this overrides recover.
REQ-030 During and after reset: out_valid=0, in_ready=1, stall=0, count=0, all out_* payload = 0.
REQ-031 Entry storage need not be reset; it SHALL never be observable while out_valid=0.
REQ-032 Reset asserted mid-stream SHALL discard all buffered bundles.

Verification
REQ-033 Fill: DEPTH=4, out_ready=0, push 4 bundles with in_prd[0]=1,2,3,4 -> count=4, in_ready=0, stall=1; a 5th in_valid is dropped.
REQ-034 Drain order: from full, hold out_ready=1 -> out_prd[0] reads 1,2,3,4 on consecutive cycles, then out_valid=0 and count=0.
REQ-035 Full push+pop: count=4, in_valid=1 with in_prd[0]=9, out_ready=1 -> count stays 4, and 9 emerges after 4 pops.
REQ-036 Wrap-around: 10 push/pop pairs with out_ready toggling -> data matches a reference queue, pointers wrap, count never exceeds 4.
REQ-037 Recover: count=3, recover=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; the pushed bundle is not stored.
REQ-038 Reset mid-operation: count=2, reset=0 for one cycle -> count=0, out_valid=0, stall=0; a later push of in_prd[0]=7 emerges first.
